mdio_responder: RTL and testbench
=================================

# mdio_responder

PHY-side MDIO management responder: the far end of the MDIO generator/transmitter. It samples the serial frame driven by the generator on MDIO_OUT/MDC, decodes ST/OP/PHYAD/REGAD, and either performs a register write or drives read data back to the generator on MDIO_IN. It sits between the MDIO bus wires and a 32×16 management register file.

## Interface
- PHY_ADDR, 5'b00011, PHY address this responder answers to; frames with another PHYAD are ignored.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- MDC  input  1  management clock from the generator, synchronous to clk; high and low phases each ≥1 clk.
- MDIO_OE  input  1  generator output enable; MDIO_OUT is valid only while high.
- MDIO_OUT  input  1  serial frame bit from the generator.
- RD_DATA  input  16  register-file read data for REG_ADDR; must be valid by the MDC rising edge of frame bit 14.
- MDIO_IN  output  1  serial read data to the generator.
- MDIO_ENABLE  output  1  high while the responder drives MDIO_IN.
- REG_ADDR  output  5  REGAD of the current or last frame.
- WR_DATA  output  16  write payload.
- WR_STB  output  1  one-clk write strobe.
- RD_REQ  output  1  one-clk read request; REG_ADDR is valid with it.
- FRAME_ERR  output  1  one-clk pulse on a malformed or aborted frame.

## Operation
- MDC edge detection: mdc_q is MDC registered; rise = MDC & ~mdc_q, fall = ~MDC & mdc_q. All frame activity is qualified by these strobes.
- Frame format, MSB first, bits 0..31: ST[1:0]=01, OP[1:0] (01 write, 10 read), PHYAD[4:0], REGAD[4:0], TA[1:0], DATA[15:0].
- Bit counter (5 bits) counts the rise events of the current frame. MDIO_OUT is sampled into a shift register on rise while MDIO_OE=1.
- States:
  - IDLE: the first rise with MDIO_OE=1 is bit 0; go to HDR.
  - HDR: collect bits 0–13.
    - After bit 1: if ST≠01, pulse FRAME_ERR and go to ABORT.
    - After bit 3: if OP∉{01,10}, pulse FRAME_ERR and go to ABORT.
    - After bit 8: if PHYAD≠PHY_ADDR, go to SKIP, with no error.
    - After bit 13: latch REG_ADDR. Write goes to WR_BODY; read pulses RD_REQ and goes to RD_TA.
  - WR_BODY: collect bits 14–31; TA values are ignored. After the bit-31 rise, latch WR_DATA and pulse WR_STB in the next clk; go to IDLE. If any rise in bits 14–31 sees MDIO_OE=0, pulse FRAME_ERR, go to ABORT, and assert no WR_STB.
  - RD_TA: on the bit-14 rise, load rd_sh←RD_DATA. On the following fall, set MDIO_ENABLE=1 and MDIO_IN=0 (TA second bit). MDIO_OE is ignored from bit 14 onward. On the bit-15 rise, go to RD_DATA.
  - RD_DATA: on each fall, drive MDIO_IN←rd_sh[15] and shift rd_sh left. Frame bit k (16..31) therefore carries RD_DATA[31−k]. On the bit-31 rise, clear MDIO_ENABLE and MDIO_IN; go to IDLE.
  - ABORT / SKIP: wait for a rise with MDIO_OE=0 (ABORT), or for 32 total rises (SKIP). Outputs stay idle. Return to IDLE.
- A new MDIO_OE-qualified frame starts only from IDLE.

## Timing
- Reset (rst=0 at a clk edge) gives the following in the next cycle: state IDLE, counter 0, MDIO_IN=0, MDIO_ENABLE=0, WR_STB=0, RD_REQ=0, FRAME_ERR=0, REG_ADDR=0, WR_DATA=0. This applies mid-frame too; no strobe is issued for the interrupted frame.
- Edge detection latency: 1 clk after the MDC edge is visible at clk.
- WR_STB: exactly 1 clk, 1 clk after bit-31 rise detection. WR_DATA and REG_ADDR are stable from WR_STB until the next frame's bit 13.
- RD_REQ: 1 clk, asserted with the bit-13 rise detection. RD_DATA is sampled at the bit-14 rise.
- MDIO_IN is updated only on fall, so it is stable across every generator sampling rise.
- MDIO_ENABLE is high from the fall after bit 14 through the bit-31 rise (inclusive).
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Write: frame 0101_00011_00110_10 + 0xABCD -> WR_STB one clk with REG_ADDR=6 and WR_DATA=0xABCD; MDIO_ENABLE stays 0.
- Read: frame 0110_00011_00110, generator releases OE, RD_DATA=0xAE53 -> RD_REQ once with REG_ADDR=6; MDIO_IN=0 at bit 15, then 1010_1110_0101_0011 at bits 16–31; MDIO_ENABLE low after bit 31.
- Foreign PHY: write frame with PHYAD=00101 -> no WR_STB, no FRAME_ERR, no drive; the next valid write is accepted.
- Bad ST 00 or OP 11 -> FRAME_ERR one clk, no strobes; IDLE after OE drops.
- MDIO_OE drops at write bit 20 -> FRAME_ERR, no WR_STB.
- rst=0 for 4 clk during read bit 22 -> MDIO_IN=0 and MDIO_ENABLE=0 next cycle; a following write frame is decoded correctly.

Source files
------------

// File: rtl/mdio_responder.sv
// -----------------------------------------------------------------------------
// mdio_responder
//
// PHY-side MDIO management responder. It samples the serial frame that an MDIO
// generator drives on MDIO_OUT/MDC, decodes ST/OP/PHYAD/REGAD and then either
// performs a register write (WR_STB/WR_DATA/REG_ADDR) or returns register read
// data serially on MDIO_IN.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   MDC          management clock from the generator (synchronous to clk)
//   MDIO_OE      generator output enable; MDIO_OUT is only meaningful when high
//   MDIO_OUT     serial frame bit from the generator
//   RD_DATA      register-file read data for REG_ADDR
//   MDIO_IN      serial read data back to the generator
//   MDIO_ENABLE  high while this block drives MDIO_IN
//   REG_ADDR     REGAD of the current or last frame
//   WR_DATA      write payload
//   WR_STB       one-clk write strobe
//   RD_REQ       one-clk read request (REG_ADDR valid with it)
//   FRAME_ERR    one-clk pulse on a malformed or aborted frame
//
// Register-file read contract: RD_REQ pulses for one clk together with a valid
// REG_ADDR; the register file has until the bit-14 MDC rise to present RD_DATA,
// which is captured exactly once at that rise. There is no back-pressure.
// -----------------------------------------------------------------------------
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'b00011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDC,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_ENABLE,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_REQ,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WR_BODY, S_RD_TA, S_RD_DATA, S_ABORT, S_SKIP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_mdc_q;
  logic        w_rise;
  logic        w_fall;
  logic [4:0]  r_cnt;        // index of the next frame bit (rise) expected
  logic [4:0]  w_cnt_nxt;
  logic [15:0] r_sh;
  logic [15:0] w_sh_nxt;
  logic [15:0] r_rd_sh;
  logic        r_op_wr;
  logic        w_err;
  logic        w_wr;
  logic        w_rd_req;
  logic        w_lat_op;
  logic        w_lat_reg;
  logic        w_load_rd;
  logic        w_ta;
  logic        w_shift_out;
  logic        w_release;

  assign w_rise   = MDC & ~r_mdc_q;
  assign w_fall   = ~MDC & r_mdc_q;
  // Shift-register contents including the bit arriving on this rise, so the
  // field checks below see the field that has just completed.
  assign w_sh_nxt = {r_sh[14:0], MDIO_OUT};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err       = 1'b0;
    w_wr        = 1'b0;
    w_rd_req    = 1'b0;
    w_lat_op    = 1'b0;
    w_lat_reg   = 1'b0;
    w_load_rd   = 1'b0;
    w_ta        = 1'b0;
    w_shift_out = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise && MDIO_OE) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 5'd1;
        end
      end
      S_HDR: begin
        if (w_rise) begin
          if (!MDIO_OE) begin
            // Generator let go in the middle of the header: nothing left to wait for.
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
            case (r_cnt)
              5'd1: begin
                if (w_sh_nxt[1:0] != 2'b01) begin
                  w_err       = 1'b1;
                  w_state_nxt = S_ABORT;
                end
              end
              5'd3: begin
                if (w_sh_nxt[1:0] == 2'b01 || w_sh_nxt[1:0] == 2'b10) begin
                  w_lat_op = 1'b1;
                end else begin
                  w_err       = 1'b1;
                  w_state_nxt = S_ABORT;
                end
              end
              5'd8: begin
                if (w_sh_nxt[4:0] != PHY_ADDR) w_state_nxt = S_SKIP;
              end
              5'd13: begin
                w_lat_reg = 1'b1;
                if (r_op_wr) begin
                  w_state_nxt = S_WR_BODY;
                end else begin
                  w_rd_req    = 1'b1;
                  w_state_nxt = S_RD_TA;
                end
              end
              default: ;
            endcase
          end
        end
      end
      S_WR_BODY: begin
        if (w_rise) begin
          if (!MDIO_OE) begin
            w_err       = 1'b1;
            w_state_nxt = S_ABORT;
          end else if (r_cnt == 5'd31) begin
            w_wr        = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      S_RD_TA: begin
        if (w_rise) begin
          if (r_cnt == 5'd14) begin
            w_load_rd = 1'b1;
            w_cnt_nxt = 5'd15;
          end else begin
            w_state_nxt = S_RD_DATA;
            w_cnt_nxt   = 5'd16;
          end
        end else if (w_fall && r_cnt == 5'd15) begin
          // Second turnaround bit: start driving a 0.
          w_ta = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (w_rise) begin
          if (r_cnt == 5'd31) begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end else if (w_fall) begin
          w_shift_out = 1'b1;
        end
      end
      S_ABORT: begin
        if (w_rise && !MDIO_OE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 5'd0;
        end
      end
      S_SKIP: begin
        // Foreign frame: ride out all 32 rises so its data bits are not
        // mistaken for the start of a new frame.
        if (w_rise) begin
          if (r_cnt == 5'd31) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mdc_q     <= 1'b0;
      r_cnt       <= 5'd0;
      r_sh        <= 16'd0;
      r_rd_sh     <= 16'd0;
      r_op_wr     <= 1'b0;
      MDIO_IN     <= 1'b0;
      MDIO_ENABLE <= 1'b0;
      REG_ADDR    <= 5'd0;
      WR_DATA     <= 16'd0;
      WR_STB      <= 1'b0;
      RD_REQ      <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdc_q   <= MDC;
      r_cnt     <= w_cnt_nxt;
      WR_STB    <= w_wr;
      RD_REQ    <= w_rd_req;
      FRAME_ERR <= w_err;
      if (w_rise && MDIO_OE) r_sh <= w_sh_nxt;
      if (w_lat_op)  r_op_wr  <= (w_sh_nxt[1:0] == 2'b01);
      if (w_lat_reg) REG_ADDR <= w_sh_nxt[4:0];
      if (w_wr)      WR_DATA  <= w_sh_nxt;
      if (w_load_rd) r_rd_sh  <= RD_DATA;
      // MDIO_IN only moves on MDC falls so it is stable at every generator rise.
      if (w_ta) begin
        MDIO_ENABLE <= 1'b1;
        MDIO_IN     <= 1'b0;
      end else if (w_shift_out) begin
        MDIO_IN <= r_rd_sh[15];
        r_rd_sh <= {r_rd_sh[14:0], 1'b0};
      end else if (w_release) begin
        MDIO_ENABLE <= 1'b0;
        MDIO_IN     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_responder
//
// Drives MDIO frames bit by bit with randomised MDC phase lengths, monitors the
// register-file side strobes and checks them against a frame-level model that
// classifies each frame (error / write / read / ignored) from its fields.
// -----------------------------------------------------------------------------
module tb_mdio_responder;

  localparam logic [4:0] PHY = 5'b00011;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MDC = 1'b0;
  logic        MDIO_OE = 1'b0;
  logic        MDIO_OUT = 1'b0;
  logic [15:0] RD_DATA = 16'd0;
  logic        MDIO_IN;
  logic        MDIO_ENABLE;
  logic [4:0]  REG_ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_REQ;
  logic        FRAME_ERR;

  always #5 clk = ~clk;

  mdio_responder #(.PHY_ADDR(PHY)) dut (
    .clk(clk), .rst(rst), .MDC(MDC), .MDIO_OE(MDIO_OE), .MDIO_OUT(MDIO_OUT),
    .RD_DATA(RD_DATA), .MDIO_IN(MDIO_IN), .MDIO_ENABLE(MDIO_ENABLE),
    .REG_ADDR(REG_ADDR), .WR_DATA(WR_DATA), .WR_STB(WR_STB), .RD_REQ(RD_REQ),
    .FRAME_ERR(FRAME_ERR)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- monitor / scoreboard ----------------
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          err_cnt = 0;
  int          en_cycles = 0;
  int          wide_cnt = 0;
  logic [4:0]  rdreq_addr = 5'd0;
  logic        p_wr = 1'b0;
  logic        p_rd = 1'b0;
  logic        p_err = 1'b0;
  logic [20:0] wr_q[$];
  logic [20:0] exp_q[$];

  always @(negedge clk) begin
    if (WR_STB === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      wr_q.push_back({REG_ADDR, WR_DATA});
    end
    if (RD_REQ === 1'b1) begin
      rd_cnt     <= rd_cnt + 1;
      rdreq_addr <= REG_ADDR;
    end
    if (FRAME_ERR === 1'b1) err_cnt <= err_cnt + 1;
    if (MDIO_ENABLE === 1'b1) en_cycles <= en_cycles + 1;
    if ((WR_STB === 1'b1 && p_wr) || (RD_REQ === 1'b1 && p_rd) ||
        (FRAME_ERR === 1'b1 && p_err)) wide_cnt <= wide_cnt + 1;
    p_wr  <= (WR_STB === 1'b1);
    p_rd  <= (RD_REQ === 1'b1);
    p_err <= (FRAME_ERR === 1'b1);
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic err; logic wr; logic rd; } exp_t;

  // Frame-level outcome: f holds frame bit k at f[31-k]; OE is high for bits
  // 0..oe_last.
  function automatic exp_t model(input logic [31:0] f, input int oe_last);
    exp_t e;
    e = '0;
    if (f[31:30] != 2'b01) e.err = 1'b1;
    else if (f[29:28] != 2'b01 && f[29:28] != 2'b10) e.err = 1'b1;
    else if (f[27:23] == PHY) begin
      if (f[29:28] == 2'b01) begin
        if (oe_last < 31) e.err = 1'b1;
        else e.wr = 1'b1;
      end else begin
        e.rd = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] ra,
                                     input logic [15:0] d);
    return {st, op, phy, ra, 2'b10, d};
  endfunction

  // ---------------- drivers ----------------
  // One MDC period: low phase (data set up), sample the responder just before
  // the rise as the generator would, then high phase.
  task automatic drive_bit(input logic b, input logic oe, output logic din, output logic den);
    int lo;
    int hi;
    lo = $urandom_range(1, 3);
    hi = $urandom_range(1, 3);
    MDIO_OUT = b;
    MDIO_OE  = oe;
    MDC      = 1'b0;
    repeat (lo) @(negedge clk);
    din = MDIO_IN;
    den = MDIO_ENABLE;
    MDC = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f, input int oe_last,
                            output logic [31:0] s_in, output logic [31:0] s_en,
                            output int d_wr, output int d_rd, output int d_err,
                            output int d_en, output int d_wide);
    int w0, r0, e0, n0, x0;
    logic din, den;
    #1;
    wr_q.delete();
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; n0 = en_cycles; x0 = wide_cnt;
    for (int k = 0; k < 32; k++) begin
      drive_bit(f[31-k], (k <= oe_last), din, den);
      s_in[k] = din;
      s_en[k] = den;
    end
    for (int k = 0; k < 3; k++) drive_bit(1'b0, 1'b0, din, den);
    repeat (2) @(negedge clk);
    #1;
    d_wr = wr_cnt - w0; d_rd = rd_cnt - r0; d_err = err_cnt - e0;
    d_en = en_cycles - n0; d_wide = wide_cnt - x0;
  endtask

  // ---------------- tests ----------------
  logic [31:0] s_in, s_en;
  int          d_wr, d_rd, d_err, d_en, d_wide;

  task automatic test_reset();
    MDC = 1'b1;
    repeat (2) @(negedge clk);
    MDC = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({MDIO_IN, MDIO_ENABLE, WR_STB, RD_REQ, FRAME_ERR} !== 5'b0) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {MDIO_IN, MDIO_ENABLE, WR_STB, RD_REQ, FRAME_ERR});
    end
    n_vec++;
    if (REG_ADDR !== 5'd0) begin
      n_miss++; $display("FAIL reset_reg_addr: got %0h expected 0", REG_ADDR);
    end
    n_vec++;
    if (WR_DATA !== 16'd0) begin
      n_miss++; $display("FAIL reset_wr_data: got %0h expected 0", WR_DATA);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    logic [4:0]  ra;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      ra = (i == 0) ? 5'd6 : 5'($urandom);
      d  = (i == 0) ? 16'hABCD : 16'($urandom);
      exp_q.push_back({ra, d});
      send_frame(mk(2'b01, 2'b01, PHY, ra, d), 31, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
      n_vec++;
      if (d_wr !== 1 || d_wide !== 0) begin
        n_miss++; $display("FAIL write_stb: got %0d strobes (%0d wide) expected 1", d_wr, d_wide);
      end
      n_vec++;
      if (wr_q[0] !== exp_q[0]) begin
        n_miss++; $display("FAIL write_data: got %h expected %h", wr_q[0], exp_q[0]);
      end
      void'(exp_q.pop_front());
      n_vec++;
      if (d_en !== 0 || d_err !== 0 || d_rd !== 0) begin
        n_miss++; $display("FAIL write_side: got en=%0d err=%0d rd=%0d expected 0", d_en, d_err, d_rd);
      end
      n_vec++;
      if ({REG_ADDR, WR_DATA} !== {ra, d}) begin
        n_miss++; $display("FAIL write_hold: got %h expected %h", {REG_ADDR, WR_DATA}, {ra, d});
      end
    end
  endtask

  task automatic test_read();
    logic [4:0]  ra;
    logic [15:0] got;
    for (int i = 0; i < 3; i++) begin
      ra      = (i == 0) ? 5'd6 : 5'($urandom);
      RD_DATA = (i == 0) ? 16'hAE53 : 16'($urandom);
      send_frame(mk(2'b01, 2'b10, PHY, ra, 16'h0), 13, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
      for (int k = 16; k < 32; k++) got[31-k] = s_in[k];
      n_vec++;
      if (d_rd !== 1 || rdreq_addr !== ra) begin
        n_miss++; $display("FAIL read_req: got %0d reqs addr %0h expected 1 addr %0h", d_rd, rdreq_addr, ra);
      end
      n_vec++;
      if (s_in[15] !== 1'b0) begin
        n_miss++; $display("FAIL read_ta: got %b expected 0", s_in[15]);
      end
      n_vec++;
      if (got !== RD_DATA) begin
        n_miss++; $display("FAIL read_data: got %h expected %h", got, RD_DATA);
      end
      n_vec++;
      if (s_en !== 32'hFFFF_8000) begin
        n_miss++; $display("FAIL read_enable: got %h expected ffff8000", s_en);
      end
      n_vec++;
      if (MDIO_ENABLE !== 1'b0 || MDIO_IN !== 1'b0 || d_wr !== 0 || d_err !== 0) begin
        n_miss++; $display("FAIL read_end: got en=%b in=%b wr=%0d err=%0d expected 0",
                           MDIO_ENABLE, MDIO_IN, d_wr, d_err);
      end
    end
  endtask

  task automatic test_foreign_phy();
    logic [15:0] d;
    d = 16'($urandom);
    send_frame(mk(2'b01, 2'b01, 5'b00101, 5'd9, d), 31, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
    n_vec++;
    if (d_wr !== 0 || d_err !== 0 || d_en !== 0 || d_rd !== 0) begin
      n_miss++; $display("FAIL foreign_wr: got wr=%0d err=%0d en=%0d rd=%0d expected 0", d_wr, d_err, d_en, d_rd);
    end
    RD_DATA = 16'hFFFF;
    send_frame(mk(2'b01, 2'b10, 5'b10011, 5'd9, 16'h0), 13, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
    n_vec++;
    if (d_rd !== 0 || d_err !== 0 || d_en !== 0) begin
      n_miss++; $display("FAIL foreign_rd: got rd=%0d err=%0d en=%0d expected 0", d_rd, d_err, d_en);
    end
    exp_q.push_back({5'd17, d});
    send_frame(mk(2'b01, 2'b01, PHY, 5'd17, d), 31, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
    n_vec++;
    if (d_wr !== 1 || wr_q[0] !== exp_q[0]) begin
      n_miss++; $display("FAIL foreign_next: got %0d strobes data %h expected 1 data %h", d_wr, wr_q[0], exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_bad_header();
    logic [1:0] st_tab[2];
    logic [1:0] op_tab[2];
    st_tab[0] = 2'b00; op_tab[0] = 2'b01;
    st_tab[1] = 2'b01; op_tab[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      send_frame(mk(st_tab[i], op_tab[i], PHY, 5'd3, 16'h1234), 31, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
      n_vec++;
      if (d_err !== 1 || d_wide !== 0) begin
        n_miss++; $display("FAIL bad_hdr_err%0d: got %0d pulses (%0d wide) expected 1", i, d_err, d_wide);
      end
      n_vec++;
      if (d_wr !== 0 || d_rd !== 0 || d_en !== 0) begin
        n_miss++; $display("FAIL bad_hdr_strobe%0d: got wr=%0d rd=%0d en=%0d expected 0", i, d_wr, d_rd, d_en);
      end
    end
    exp_q.push_back({5'd4, 16'h5A5A});
    send_frame(mk(2'b01, 2'b01, PHY, 5'd4, 16'h5A5A), 31, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
    n_vec++;
    if (d_wr !== 1 || wr_q[0] !== exp_q[0]) begin
      n_miss++; $display("FAIL bad_hdr_next: got %0d strobes data %h expected 1 data %h", d_wr, wr_q[0], exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_oe_drop();
    send_frame(mk(2'b01, 2'b01, PHY, 5'd12, 16'hC3C3), 19, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
    n_vec++;
    if (d_err !== 1 || d_wr !== 0) begin
      n_miss++; $display("FAIL oe_drop: got err=%0d wr=%0d expected err=1 wr=0", d_err, d_wr);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] f;
    logic        din, den;
    int          en0;
    RD_DATA = 16'($urandom) | 16'h0200;
    f = mk(2'b01, 2'b10, PHY, 5'd21, 16'h0);
    for (int k = 0; k < 22; k++) drive_bit(f[31-k], (k <= 13), din, den);
    MDC = 1'b0;
    MDIO_OE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (MDIO_ENABLE !== 1'b1 || MDIO_IN !== 1'b1) begin
      n_miss++; $display("FAIL rst_pre: got en=%b in=%b expected 1 1", MDIO_ENABLE, MDIO_IN);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (MDIO_ENABLE !== 1'b0 || MDIO_IN !== 1'b0 || REG_ADDR !== 5'd0) begin
      n_miss++; $display("FAIL rst_mid: got en=%b in=%b addr=%0h expected 0", MDIO_ENABLE, MDIO_IN, REG_ADDR);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    en0 = en_cycles;
    for (int k = 22; k < 35; k++) drive_bit(1'b1, 1'b0, din, den);
    #1;
    n_vec++;
    if (en_cycles !== en0) begin
      n_miss++; $display("FAIL rst_tail: got %0d drive cycles expected 0", en_cycles - en0);
    end
    exp_q.push_back({5'd30, 16'h0F1E});
    send_frame(mk(2'b01, 2'b01, PHY, 5'd30, 16'h0F1E), 31, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
    n_vec++;
    if (d_wr !== 1 || wr_q[0] !== exp_q[0]) begin
      n_miss++; $display("FAIL rst_next: got %0d strobes data %h expected 1 data %h", d_wr, wr_q[0], exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [1:0]  st, op;
    logic [4:0]  phy, ra;
    logic [15:0] d, got;
    logic [31:0] f;
    int          oe_last;
    exp_t        e;
    for (int i = 0; i < 16; i++) begin
      st  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      op  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3))
                                        : (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      phy = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY;
      ra  = 5'($urandom);
      d   = 16'($urandom);
      oe_last = (op == 2'b10) ? 13 : (($urandom_range(0, 4) == 0) ? $urandom_range(13, 30) : 31);
      RD_DATA = 16'($urandom);
      f = mk(st, op, phy, ra, d);
      e = model(f, oe_last);
      if (e.wr) exp_q.push_back({ra, d});
      send_frame(f, oe_last, s_in, s_en, d_wr, d_rd, d_err, d_en, d_wide);
      n_vec++;
      if (d_wr !== int'(e.wr) || d_rd !== int'(e.rd) || d_err !== int'(e.err) || d_wide !== 0) begin
        n_miss++;
        $display("FAIL mix%0d_class: got wr=%0d rd=%0d err=%0d wide=%0d expected wr=%0d rd=%0d err=%0d (frame %h oe_last %0d)",
                 i, d_wr, d_rd, d_err, d_wide, e.wr, e.rd, e.err, f, oe_last);
      end
      if (e.wr) begin
        n_vec++;
        if (wr_q[0] !== exp_q[0]) begin
          n_miss++; $display("FAIL mix%0d_wdata: got %h expected %h", i, wr_q[0], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (e.rd) begin
        for (int k = 16; k < 32; k++) got[31-k] = s_in[k];
        n_vec++;
        if (got !== RD_DATA || rdreq_addr !== ra) begin
          n_miss++; $display("FAIL mix%0d_rdata: got %h addr %0h expected %h addr %0h", i, got, rdreq_addr, RD_DATA, ra);
        end
      end else begin
        n_vec++;
        if (d_en !== 0) begin
          n_miss++; $display("FAIL mix%0d_drive: got %0d drive cycles expected 0", i, d_en);
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_foreign_phy();
    test_bad_header();
    test_oe_drop();
    test_reset_mid_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1);
  end

endmodule
